// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain
//   Elastic pipeline register chain: DEPTH registered stages carrying a
//   WIDTH-bit payload with valid/ready handshake at both ends, bubble
//   collapsing, per-stage kill, global flush, optional one-entry input skid
//   buffer (SKID=1) and a registered occupancy count.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   upstream offers in_data
//   in_ready   chain accepts in_data this cycle
//   in_data    input payload
//   out_valid  last stage holds a live (not killed) item
//   out_ready  downstream consumes out_data this cycle
//   out_data   payload of the last stage
//   kill       bit i squashes the item held in stage i at this edge
//   flush      clears every stage and the skid entry at this edge
//   count      live entries (stages plus skid) after the most recent edge
// -----------------------------------------------------------------------------
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  parameter int SKID  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  input  logic [DEPTH-1:0]              kill,
  input  logic                          flush,
  output logic [$clog2(DEPTH+2)-1:0]    count
);

  localparam int CW = $clog2(DEPTH+2);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_lv;      // stage holds an item that survives this edge
  logic [DEPTH-1:0] w_adv;     // stage may take the item from its upstream neighbour
  logic [DEPTH-1:0] w_up_v;    // live item offered to each stage from upstream
  logic [DEPTH-1:0] w_v_nxt;
  logic             w_src_v;   // stage 0 source (skid entry or input)
  logic [WIDTH-1:0] w_src_d;
  logic             w_sv_nxt;
  logic [CW-1:0]    w_cnt_nxt;

  always_comb begin
    w_lv = r_v & ~kill;
  end

  // A stage advances when the stage ahead advances or when it is itself empty,
  // so bubbles collapse behind a stalled head.
  always_comb begin
    w_adv = '0;
    w_adv[DEPTH-1] = out_ready | ~w_lv[DEPTH-1];
    for (int unsigned k = 1; k < DEPTH; k++) begin
      w_adv[DEPTH-1-k] = w_adv[DEPTH-k] | ~w_lv[DEPTH-1-k];
    end
  end

  generate
    if (SKID == 0) begin : g_noskid
      always_comb begin
        in_ready = w_adv[0] & ~flush;
        w_src_v  = in_valid & in_ready;
        w_src_d  = in_data;
        w_sv_nxt = 1'b0;
      end
    end else begin : g_skid
      logic             r_sv;
      logic [WIDTH-1:0] r_sd;
      logic             w_acc;

      // in_ready depends only on registered state and flush, breaking the
      // out_ready -> in_ready combinational path.
      always_comb begin
        in_ready = ~r_sv & ~flush;
        w_acc    = in_valid & in_ready;
        w_src_v  = r_sv | w_acc;
        w_src_d  = r_sv ? r_sd : in_data;
        w_sv_nxt = 1'b0;
        if (flush)                   w_sv_nxt = 1'b0;
        else if (r_sv)               w_sv_nxt = ~w_adv[0];
        else if (w_acc && !w_adv[0]) w_sv_nxt = 1'b1;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_sv <= 1'b0;
          r_sd <= '0;
        end else begin
          r_sv <= w_sv_nxt;
          if (!flush && w_acc && !w_adv[0]) r_sd <= in_data;
        end
      end
    end
  endgenerate

  always_comb begin
    w_up_v[0] = w_src_v;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      w_up_v[i] = w_lv[i-1];
    end
  end

  always_comb begin
    w_v_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (flush)         w_v_nxt[i] = 1'b0;
      else if (w_adv[i]) w_v_nxt[i] = w_up_v[i];
      else               w_v_nxt[i] = w_lv[i];
    end
  end

  always_comb begin
    w_cnt_nxt = CW'(w_sv_nxt);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + CW'(w_v_nxt[i]);
    end
  end

  // Data registers load only when a live item actually moves in, so bubble
  // moves and flushes leave them untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v     <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_d[i] <= '0;
      end
    end else begin
      r_v     <= w_v_nxt;
      r_count <= w_cnt_nxt;
      if (!flush && w_adv[0] && w_up_v[0]) r_d[0] <= w_src_d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (!flush && w_adv[i] && w_up_v[i]) r_d[i] <= r_d[i-1];
      end
    end
  end

  always_comb begin
    out_valid = w_lv[DEPTH-1];
    out_data  = r_d[DEPTH-1];
    count     = r_count;
  end

endmodule
